// File: rtl/sequencer_pkg.sv
// Shared step-sequencer definitions: grid geometry, step index type and scan FSM states.
package sequencer_pkg;
   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef logic [3:0] step_idx_t;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_e;
endpackage

// File: rtl/led_row_timer.sv
// Row slot timer: counts each row slot, splits it into a BLANK then DRIVE phase
// and steps the scanned row.
module led_row_timer
   import sequencer_pkg::*;
#(
   parameter int ROW_DWELL_CYCLES = 12000,
   parameter int BLANK_CYCLES     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output scan_state_e state_o,
   output logic [1:0]  row_o,
   output logic        frame_evt_o,
   output logic        drive_start_o
);
   localparam int CNT_W = $clog2(ROW_DWELL_CYCLES);

   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       row_q;
   scan_state_e      state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         row_q   <= '0;
         state_q <= ST_BLANK;
      end else if (cnt_q == CNT_W'(ROW_DWELL_CYCLES - 1)) begin
         cnt_q   <= '0;
         row_q   <= row_q + 2'd1;
         state_q <= ST_BLANK;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
         if (state_q == ST_BLANK && cnt_q == CNT_W'(BLANK_CYCLES - 1))
            state_q <= ST_DRIVE;
      end
   end

   // Both strobes mark the cycle *before* the event lands in the registered outputs.
   assign drive_start_o = (state_q == ST_BLANK) && (cnt_q == CNT_W'(BLANK_CYCLES - 1));
   assign frame_evt_o   = (state_q == ST_BLANK) && (cnt_q == '0) && (row_q == 2'd0);
   assign state_o       = state_q;
   assign row_o         = row_q;
endmodule

// File: rtl/led_matrix_driver.sv
// 4x4 step-sequencer LED matrix scanner with per-row blanking, PWM brightness
// and a blinking playhead overlay.
module led_matrix_driver
   import sequencer_pkg::*;
#(
   parameter int ROW_DWELL_CYCLES = 12000,
   parameter int BLANK_CYCLES     = 16,
   parameter int BLINK_FRAMES     = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  step_idx_t                 wr_index,
   input  logic                      wr_data,
   input  logic                      load_en,
   input  logic [15:0]               load_data,
   input  step_idx_t                 beat_index,
   input  logic                      playhead_en,
   input  logic [2:0]                brightness,
   output logic [NUM_ROWS-1:0]       row_outputs,
   output logic [NUM_COLS-1:0]       col_outputs,
   output logic                      frame_start
);
   localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   scan_state_e          state;
   logic [1:0]           row;
   logic                 frame_evt, drive_start;

   logic [15:0]          fb_q, fb_d;
   logic [NUM_COLS-1:0]  snap_q, snap_d, ovl;
   logic [2:0]           bright_q, pwm_q;
   logic [FCW-1:0]       fcnt_q;
   logic                 blink_q;
   logic [NUM_ROWS-1:0]  row_q;
   logic [NUM_COLS-1:0]  col_q;
   logic                 fs_q;

   led_row_timer #(
      .ROW_DWELL_CYCLES (ROW_DWELL_CYCLES),
      .BLANK_CYCLES     (BLANK_CYCLES)
   ) u_timer (
      .clk           (clk),
      .rst_n         (rst_n),
      .state_o       (state),
      .row_o         (row),
      .frame_evt_o   (frame_evt),
      .drive_start_o (drive_start)
   );

   // A single-step write lands on top of a same-cycle whole-pattern load.
   always_comb begin
      fb_d = fb_q;
      if (load_en) fb_d = load_data;
      if (wr_en)   fb_d[wr_index] = wr_data;
   end

   always_comb begin
      ovl = '0;
      if (playhead_en && blink_q && beat_index[3:2] == row)
         ovl = NUM_COLS'(4'b0001 << beat_index[1:0]);
      snap_d = fb_q[{row, 2'b00} +: NUM_COLS] ^ ovl;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fb_q     <= '0;
         snap_q   <= '0;
         bright_q <= '0;
         pwm_q    <= '0;
         fcnt_q   <= '0;
         blink_q  <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         fs_q     <= 1'b0;
      end else begin
         fb_q <= fb_d;
         if (drive_start) begin
            snap_q   <= snap_d;
            bright_q <= brightness;
            pwm_q    <= '0;
         end else if (state == ST_DRIVE) begin
            pwm_q <= pwm_q + 3'd1;
         end
         if (frame_evt) begin
            if (fcnt_q == FCW'(BLINK_FRAMES - 1)) begin
               fcnt_q  <= '0;
               blink_q <= ~blink_q;
            end else begin
               fcnt_q <= fcnt_q + FCW'(1);
            end
         end
         row_q <= NUM_ROWS'(4'b0001 << row);
         col_q <= (state == ST_DRIVE && pwm_q <= bright_q) ? snap_q : '0;
         fs_q  <= frame_evt;
      end
   end

   assign row_outputs = row_q;
   assign col_outputs = col_q;
   assign frame_start = fs_q;
endmodule
